mc_rd_resp_buf: RTL and testbench

MC_RD_RESP_BUF -- requirements
Module: mc_rd_resp_buf

---
 rtl/mc_pkg.sv | 10 +
 rtl/mc_rd_resp_buf_if.sv | 27 ++
 rtl/mc_sync_fifo.sv | 51 +++++
 rtl/mc_rd_resp_buf.sv | 114 +++++++++++
 tb/tb_mc_rd_resp_buf.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// Shared memory-controller types: burst length width and the burst command record.
package mc_pkg;

  localparam int LEN_WIDTH = 6;

  typedef struct packed {
    logic [LEN_WIDTH-1:0] len;
  } burst_cmd_t;

endpackage

// File: rtl/mc_rd_resp_buf_if.sv
// Read response buffer bus: burst announce, array-side beats, AXI R channel, error flags.
// slave = the buffer itself, master = the environment that drives it.
interface mc_rd_resp_buf_if import mc_pkg::*; #(
  parameter int AXI_DATA_WIDTH = 64
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [LEN_WIDTH-1:0]      cmd_len;
  logic                      arr_rvalid;
  logic [AXI_DATA_WIDTH-1:0] arr_rdata;
  logic                      axi_rvalid;
  logic                      axi_rready;
  logic [AXI_DATA_WIDTH-1:0] axi_rdata;
  logic                      axi_rlast;
  logic                      err_overflow;
  logic                      err_unexp;

  modport slave (
    input  cmd_valid, cmd_len, arr_rvalid, arr_rdata, axi_rready,
    output cmd_ready, axi_rvalid, axi_rdata, axi_rlast, err_overflow, err_unexp
  );

  modport master (
    output cmd_valid, cmd_len, arr_rvalid, arr_rdata, axi_rready,
    input  cmd_ready, axi_rvalid, axi_rdata, axi_rlast, err_overflow, err_unexp
  );
endinterface

// File: rtl/mc_sync_fifo.sv
// Generic single-clock fall-through FIFO. A pop frees its slot in the same
// cycle, so push+pop at full is accepted and leaves count unchanged.
module mc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, push_ok, pop_ok;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_data = mem[rd_ptr];

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; only valid entries are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mc_rd_resp_buf.sv
// Read response buffer: reserves FIFO space per announced burst, absorbs
// array beats without backpressure and replays them on the AXI R channel
// with rlast framing. Optional sticky error flags under MC_RDBUF_ERR_EN;
// without it the error outputs are tied low (drop behaviour is identical).
module mc_rd_resp_buf import mc_pkg::*; #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int DATA_DEPTH     = 64,
  parameter int CMD_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst,
  mc_rd_resp_buf_if.slave   bus
);
  localparam int CW = $clog2(DATA_DEPTH) + 1;
  localparam int QW = $clog2(CMD_DEPTH) + 1;

  logic [AXI_DATA_WIDTH-1:0] data_head;
  logic [CW-1:0]             data_count;
  logic                      data_empty, data_full, data_push, data_pop;
  logic [QW-1:0]             cmd_count;
  logic                      cmd_empty, cmd_full, cmd_pop, cmd_accept;
  burst_cmd_t                cmd_in, cmd_head;

  logic [CW-1:0]             reserved, res_next, free, need;
  logic [CW:0]               used;
  logic                      res_nz;
  logic [LEN_WIDTH-1:0]      beat_cnt;

  assign data_full = (data_count == CW'(DATA_DEPTH));
  assign cmd_full  = (cmd_count == QW'(CMD_DEPTH));

  // Space not yet holding data nor promised to an outstanding burst; saturates at 0.
  assign used   = {1'b0, data_count} + {1'b0, reserved};
  assign free   = (used >= (CW+1)'(DATA_DEPTH)) ? '0 : CW'((CW+1)'(DATA_DEPTH) - used);
  assign need   = CW'(bus.cmd_len) + CW'(1);
  assign res_nz = (reserved != '0);

  assign bus.cmd_ready = !cmd_full && (free >= need);
  assign cmd_accept    = bus.cmd_valid && bus.cmd_ready;
  assign cmd_in.len    = bus.cmd_len;

  // Output only when both a beat and its framing command are present.
  assign bus.axi_rvalid = !data_empty && !cmd_empty;
  assign bus.axi_rdata  = data_head;
  assign bus.axi_rlast  = bus.axi_rvalid && (beat_cnt == cmd_head.len);

  assign data_pop  = bus.axi_rvalid && bus.axi_rready;
  assign cmd_pop   = data_pop && bus.axi_rlast;
  // Beats without a reservation, or with no room, are dropped.
  assign data_push = bus.arr_rvalid && res_nz && (!data_full || data_pop);

  mc_sync_fifo #(.WIDTH(AXI_DATA_WIDTH), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (data_push),
    .push_data (bus.arr_rdata),
    .pop       (data_pop),
    .pop_data  (data_head),
    .empty     (data_empty),
    .count     (data_count)
  );

  mc_sync_fifo #(.WIDTH($bits(burst_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_accept),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .empty     (cmd_empty),
    .count     (cmd_count)
  );

  // Net reservation change: add the accepted burst, retire one per arriving beat.
  always_comb begin
    res_next = reserved;
    if (cmd_accept)              res_next = res_next + need;
    if (bus.arr_rvalid && res_nz) res_next = res_next - CW'(1);
  end

  // Reservation register.
  always_ff @(posedge clk) begin
    if (rst) reserved <= '0;
    else     reserved <= res_next;
  end

  // Beat position within the head burst; wraps on the last beat.
  always_ff @(posedge clk) begin
    if (rst)           beat_cnt <= '0;
    else if (data_pop) beat_cnt <= bus.axi_rlast ? '0 : beat_cnt + LEN_WIDTH'(1);
  end

`ifdef MC_RDBUF_ERR_EN
  logic err_ovf_q, err_unexp_q;

  // Sticky error capture, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      if (bus.arr_rvalid && !res_nz)                err_unexp_q <= 1'b1;
      if (bus.arr_rvalid && data_full && !data_pop) err_ovf_q   <= 1'b1;
    end
  end

  assign bus.err_overflow = err_ovf_q;
  assign bus.err_unexp    = err_unexp_q;
`else
  assign bus.err_overflow = 1'b0;
  assign bus.err_unexp    = 1'b0;
`endif

endmodule

// File: tb/tb_mc_rd_resp_buf.sv
// Bench for mc_rd_resp_buf: directed scenarios with literal expectations plus
// a randomized phase, all compared every cycle against a queue-based model.
module tb_mc_rd_resp_buf;
  import mc_pkg::*;

  localparam int DW = 64;
  localparam int DD = 64;
  localparam int CD = 4;
`ifdef MC_RDBUF_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_rd_resp_buf_if #(.AXI_DATA_WIDTH(DW)) bus ();

  mc_rd_resp_buf #(.AXI_DATA_WIDTH(DW), .DATA_DEPTH(DD), .CMD_DEPTH(CD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: burst lengths in flight, buffered beats, outstanding reservation.
  int          m_cmd[$];
  logic [DW-1:0] m_data[$];
  int          m_res  = 0;
  int          m_beat = 0;
  bit          m_eu   = 0;
  bit          m_eo   = 0;

  // Observed R-channel handshakes.
  logic [DW-1:0] log_d[$];
  bit            log_l[$];
  int            log_t[$];

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk_log(string name, int idx, logic [DW-1:0] d, bit l);
    if (idx >= log_d.size()) begin
      checks++;
      errors++;
      $display("FAIL %s missing beat %0d (have %0d)", name, idx, log_d.size());
    end else begin
      chk({name, "_data"}, log_d[idx], d);
      chk({name, "_last"}, log_l[idx], l);
    end
  endtask

  function automatic bit m_rvalid();
    return (m_data.size() > 0) && (m_cmd.size() > 0);
  endfunction

  function automatic bit m_rlast();
    return m_rvalid() && (m_beat == m_cmd[0]);
  endfunction

  function automatic bit m_cready(int len);
    int f;
    f = DD - m_data.size() - m_res;
    if (f < 0) f = 0;
    return (m_cmd.size() < CD) && (f >= len + 1);
  endfunction

  task automatic log_clear();
    log_d.delete();
    log_l.delete();
    log_t.delete();
  endtask

  // One clock: compare outputs with the model, advance the model, cross the edge.
  task automatic cycle();
    bit ev, el, ec, pop, acc, push;
    push = 1'b0;
    #1;
    ev = m_rvalid();
    el = m_rlast();
    ec = m_cready(int'(bus.cmd_len));
    chk("rvalid", bus.axi_rvalid, ev);
    chk("cmd_ready", bus.cmd_ready, ec);
    chk("err_unexp", bus.err_unexp, m_eu);
    chk("err_overflow", bus.err_overflow, m_eo);
    if (ev) begin
      chk("rdata", bus.axi_rdata, m_data[0]);
      chk("rlast", bus.axi_rlast, el);
    end else begin
      chk("rlast_idle", bus.axi_rlast, 0);
    end
    if (bus.axi_rvalid && bus.axi_rready && !rst) begin
      log_d.push_back(bus.axi_rdata);
      log_l.push_back(bus.axi_rlast);
      log_t.push_back(cyc);
    end
    if (rst) begin
      m_cmd.delete();
      m_data.delete();
      m_res  = 0;
      m_beat = 0;
      m_eu   = 0;
      m_eo   = 0;
    end else begin
      pop = ev && bus.axi_rready;
      acc = bus.cmd_valid && ec;
      if (bus.arr_rvalid) begin
        if (m_data.size() == DD && !pop && ERR_EN) m_eo = 1;
        if (m_res == 0) begin
          if (ERR_EN) m_eu = 1;
        end else begin
          if (!(m_data.size() == DD && !pop)) push = 1;
          m_res--;
        end
      end
      if (pop) begin
        void'(m_data.pop_front());
        if (el) begin
          void'(m_cmd.pop_front());
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      if (push) m_data.push_back(bus.arr_rdata);
      if (acc) begin
        m_cmd.push_back(int'(bus.cmd_len));
        m_res += int'(bus.cmd_len) + 1;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(string name, int n, int budget);
    int k = 0;
    while (log_d.size() < n && k < budget) begin
      cycle();
      k++;
    end
    chk(name, log_d.size(), n);
  endtask

  task automatic send_cmd(int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 6'(len);
    cycle();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_len    = '0;
    bus.arr_rvalid = 1'b0;
    bus.arr_rdata  = '0;
    bus.axi_rready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rvalid", bus.axi_rvalid, 0);
    chk("rst_rlast", bus.axi_rlast, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_err_unexp", bus.err_unexp, 0);

    // Single burst of 4
    send_cmd(3);
    bus.axi_rready = 1'b1;
    log_clear();
    for (int i = 0; i < 4; i++) begin
      bus.arr_rvalid = 1'b1;
      bus.arr_rdata  = 64'hA0 + 64'(i);
      cycle();
      if (i == 0) begin
        chk("t1_first_rvalid", bus.axi_rvalid, 1);
        chk("t1_first_rdata", bus.axi_rdata, 64'hA0);
      end
    end
    bus.arr_rvalid = 1'b0;
    drain("t1_count", 4, 20);
    for (int i = 0; i < 4; i++) chk_log("t1_beat", i, 64'hA0 + 64'(i), i == 3);

    // Backpressure: 8 beats held 20 cycles, then drained
    bus.axi_rready = 1'b0;
    send_cmd(7);
    log_clear();
    for (int i = 0; i < 8; i++) begin
      bus.arr_rvalid = 1'b1;
      bus.arr_rdata  = 64'hB0 + 64'(i);
      cycle();
    end
    bus.arr_rvalid = 1'b0;
    repeat (12) cycle();
    chk("t2_stall_rvalid", bus.axi_rvalid, 1);
    chk("t2_stall_rdata", bus.axi_rdata, 64'hB0);
    chk("t2_stall_rlast", bus.axi_rlast, 0);
    bus.axi_rready = 1'b1;
    drain("t2_count", 8, 30);
    for (int i = 0; i < 8; i++) chk_log("t2_beat", i, 64'hB0 + 64'(i), i == 7);
    bus.cmd_len = 6'd63;
    #1 chk("t2_empty_ready63", bus.cmd_ready, 1);

    // Reservation: a 64-beat burst blocks even a 1-beat command until the first pop
    send_cmd(63);
    bus.cmd_len = 6'd0;
    log_clear();
    #1 chk("t3_ready_reserved", bus.cmd_ready, 0);
    for (int i = 0; i < 64; i++) begin
      bus.arr_rvalid = 1'b1;
      bus.arr_rdata  = 64'hC00 + 64'(i);
      cycle();
      if (i == 0) chk("t3_ready_before_pop", bus.cmd_ready, 0);
      if (i == 1) chk("t3_ready_after_pop", bus.cmd_ready, 1);
    end
    bus.arr_rvalid = 1'b0;
    drain("t3_count", 64, 80);
    chk_log("t3_first", 0, 64'hC00, 0);
    chk_log("t3_last", 63, 64'hC3F, 1);

    // Back-to-back bursts of 2 and 3
    log_clear();
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 6'd1;
    cycle();
    bus.cmd_len   = 6'd2;
    cycle();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.arr_rvalid = 1'b1;
      bus.arr_rdata  = 64'h10 + 64'(i);
      cycle();
    end
    bus.arr_rvalid = 1'b0;
    drain("t4_count", 5, 20);
    for (int i = 0; i < 5; i++) chk_log("t4_beat", i, 64'h10 + 64'(i), i == 1 || i == 4);
    if (log_t.size() == 5) chk("t4_no_gap", log_t[4] - log_t[0], 4);

    // Reset mid-burst, then a fresh single-beat burst
    send_cmd(7);
    log_clear();
    for (int i = 0; i < 3; i++) begin
      bus.arr_rvalid = 1'b1;
      bus.arr_rdata  = 64'h20 + 64'(i);
      cycle();
    end
    bus.arr_rvalid = 1'b0;
    chk("t5_beats_before_rst", log_d.size(), 2);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.cmd_len = 6'd0;
    #1;
    chk("t5_rst_rvalid", bus.axi_rvalid, 0);
    chk("t5_rst_cmd_ready", bus.cmd_ready, 1);
    log_clear();
    send_cmd(0);
    bus.arr_rvalid = 1'b1;
    bus.arr_rdata  = 64'h55;
    cycle();
    bus.arr_rvalid = 1'b0;
    drain("t5_count", 1, 10);
    chk_log("t5_beat", 0, 64'h55, 1);

    // Unexpected beat with no reservation
    bus.arr_rvalid = 1'b1;
    bus.arr_rdata  = 64'hDEAD;
    cycle();
    bus.arr_rvalid = 1'b0;
    chk("t6_err_unexp", bus.err_unexp, ERR_EN);
    chk("t6_rvalid", bus.axi_rvalid, 0);
    cycle();
    chk("t6_rvalid_later", bus.axi_rvalid, 0);
    chk("t6_err_sticky", bus.err_unexp, ERR_EN);
    rst = 1'b1;
    cycle();
    rst = 1'b0;

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      rst            = (n % 700 == 699);
      bus.cmd_valid  = ($urandom_range(0, 3) == 0);
      bus.cmd_len    = ($urandom_range(0, 7) == 0) ? 6'(63 - $urandom_range(0, 7))
                                                   : 6'($urandom_range(0, 15));
      bus.arr_rvalid = (m_res > 0) && ($urandom_range(0, 9) < 7);
      bus.arr_rdata  = {$urandom, $urandom};
      bus.axi_rready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    rst = 1'b0;
    bus.cmd_valid  = 1'b0;
    bus.axi_rready = 1'b1;
    for (int n = 0; n < 400 && (m_res > 0 || m_data.size() > 0); n++) begin
      bus.arr_rvalid = (m_res > 0);
      bus.arr_rdata  = {$urandom, $urandom};
      cycle();
    end
    bus.arr_rvalid = 1'b0;
    cycle();
    bus.cmd_len = 6'd63;
    #1 chk("final_empty_ready63", bus.cmd_ready, 1);
    chk("final_rvalid", bus.axi_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
